sensor_sampler: RTL and testbench
=================================

Name: sensor_sampler

Overview:
- Acquisition stage directly upstream of the three-channel relay FSM bank.
- Polls a shared ADC round-robin over channels 0..2 using a req/ack handshake.
- Averages 2^AVG_LOG2 samples per channel and presents the results as sen_1..sen_3 (16 bit each), with a one-cycle frame-valid pulse.
- Flags channels whose ADC conversion times out, and holds their last good value.

Parameters:
- AVG_LOG2, default 2: log2 of the number of samples averaged per channel per frame; legal range 0..4.
- TIMEOUT, default 8: maximum number of cycles spent in REQ without adc_ack before the channel is abandoned; must be ≥ 2.

Ports:
- clk_16ms  in  1  system clock; all logic updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  frame start permission.
- adc_req  out  1  conversion request to the ADC.
- adc_ch  out  2  channel select (0..2); valid while adc_req=1.
- adc_ack  in  1  ADC response; adc_data is valid in the same cycle.
- adc_data  in  16  unsigned sample.
- sen_1  out  16  averaged value, channel 0.
- sen_2  out  16  averaged value, channel 1.
- sen_3  out  16  averaged value, channel 2.
- sample_valid  out  1  one-cycle pulse at the end of every frame.
- err  out  3  per-channel timeout flags; bit k corresponds to channel k.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset, at the next clock edge with rst=1, from any state:
  - state IDLE
  - adc_req=0, adc_ch=0
  - sen_1..3=0, sample_valid=0, err=0, busy=0
  - accumulator, sample count, channel index and timeout counter all 0
  - a request in flight is dropped; an adc_ack arriving later is ignored.
- States: IDLE, REQ, GAP, DONE.
- IDLE:
  - enable=1 → REQ, with ch=0, count=0, acc=0.
  - Otherwise stay in IDLE.
- REQ:
  - adc_req=1 and adc_ch=ch (registered; both are asserted in the first REQ cycle).
  - adc_ack=1: acc += adc_data, count += 1, timeout counter cleared → GAP.
  - No ack: timeout counter increments. In the TIMEOUT-th consecutive cycle without ack, err[ch] is set, acc and count are cleared, sen_(ch+1) is left unchanged, and the block advances to the next channel (→ GAP, or → DONE if ch=2).
- Accumulator:
  - Width is 16+AVG_LOG2 bits; it cannot overflow.
  - Result = acc >> AVG_LOG2, truncating (floor).
- GAP (exactly 1 cycle, adc_req=0):
  - count < 2^AVG_LOG2: → REQ on the same channel.
  - count = 2^AVG_LOG2: sen_(ch+1) <= result, err[ch] cleared, acc and count cleared, then → REQ on ch+1, or → DONE if ch=2.
  - After an abandoned channel, GAP performs no update.
- DONE: sample_valid=1 for exactly this one cycle.
  - enable=1 → REQ with ch=0.
  - enable=0 → IDLE.
- enable is sampled only in IDLE and DONE. Dropping it mid-frame does not abort; the frame completes.
- adc_ack outside REQ is ignored. adc_ack held high across consecutive REQ cycles counts once per REQ entry, because GAP always intervenes.
- Latency with adc_ack returned in the first REQ cycle:
  - 2 cycles per sample
  - one frame = 1 + 3·2·2^AVG_LOG2 + 1 cycles from the enable edge to the sample_valid cycle; for AVG_LOG2=2 this is 26 cycles
  - back-to-back frames repeat every 25 cycles.
- sen_x only ever change at the GAP edge that completes their channel. They are stable for the downstream FSMs at all other times.

Test Plan:
- Reset then enable=1 with an ADC model that returns ack in the first REQ cycle, data = 100, 200, 300, 401 for channel 0, constant 0xFFFF for channel 1, and 7 for channel 2 → at the first sample_valid: sen_1=250, sen_2=0xFFFF, sen_3=7, err=000, and sample_valid is 1 for exactly one cycle, at cycle 26.
- Channel 1 never acks, TIMEOUT=8, and a previous frame left sen_2=0x1234 → adc_req stays high for 8 cycles on adc_ch=1, then err=010 and sen_2 stays 0x1234. The next frame with a normal ack clears err[1].
- Apply rst during REQ of channel 2, mid-accumulation → next cycle adc_req=0, busy=0, sen_1..3=0, err=0. A late adc_ack is ignored, and there is no sample_valid.
- Deassert enable in the middle of channel 1 → the frame completes and the sample_valid pulse occurs, then the block enters IDLE with adc_req=0. Re-asserting enable restarts at adc_ch=0.
- Ack delayed by 3 cycles and held high for 2 cycles, AVG_LOG2=0 → one sample is taken per REQ entry, and sen_x = the data present on the first ack cycle.
- Pulse adc_ack while in IDLE and during GAP → no accumulation occurs, and sen_x values are unchanged.

Source files
------------

// File: rtl/sensor_sampler.sv
// Round-robin ADC poller: averages 2^AVG_LOG2 samples on each of three channels per
// frame, flags channels whose conversion times out, and pulses sample_valid per frame.
module sensor_sampler #(
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 8
) (
    input  logic        clk_16ms,
    input  logic        rst,
    input  logic        enable,
    output logic        adc_req,
    output logic [1:0]  adc_ch,
    input  logic        adc_ack,
    input  logic [15:0] adc_data,
    output logic [15:0] sen_1,
    output logic [15:0] sen_2,
    output logic [15:0] sen_3,
    output logic        sample_valid,
    output logic [2:0]  err,
    output logic        busy
);

    localparam int ACC_W = 16 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] SAMPLES  = CNT_W'(1 << AVG_LOG2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ch_q, ch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [2:0]         err_q, err_d;
    logic [15:0]        sen_q [3];
    logic [15:0]        sen_d [3];
    logic               adc_req_q, adc_req_d;
    logic [1:0]         adc_ch_q, adc_ch_d;
    logic               sample_valid_q, sample_valid_d;
    logic               busy_q, busy_d;
    logic [2:0]         ch_sel;

    always_ff @(posedge clk_16ms) begin : state_reg
        if (rst) begin
            state_q        <= IDLE;
            ch_q           <= '0;
            cnt_q          <= '0;
            acc_q          <= '0;
            tmo_q          <= '0;
            err_q          <= '0;
            adc_req_q      <= 1'b0;
            adc_ch_q       <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                sen_q[k] <= '0;
            end
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            tmo_q          <= tmo_d;
            err_q          <= err_d;
            adc_req_q      <= adc_req_d;
            adc_ch_q       <= adc_ch_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            for (int k = 0; k < 3; k++) begin
                sen_q[k] <= sen_d[k];
            end
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        for (int k = 0; k < 3; k++) begin
            sen_d[k] = sen_q[k];
        end
        ch_sel = 3'b001 << ch_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = REQ;
                    ch_d    = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    tmo_d   = '0;
                end
            end
            REQ: begin
                if (adc_ack) begin
                    acc_d   = acc_q + ACC_W'(adc_data);
                    cnt_d   = cnt_q + CNT_W'(1);
                    tmo_d   = '0;
                    state_d = GAP;
                end else if (tmo_q == TMO_LAST) begin
                    // Abandon the channel; its sen register keeps the last good value.
                    err_d = err_q | ch_sel;
                    acc_d = '0;
                    cnt_d = '0;
                    tmo_d = '0;
                    if (ch_q == 2'd2) begin
                        state_d = DONE;
                        ch_d    = '0;
                    end else begin
                        state_d = GAP;
                        ch_d    = ch_q + 2'd1;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == SAMPLES) begin
                    for (int k = 0; k < 3; k++) begin
                        if (ch_sel[k]) begin
                            sen_d[k] = 16'(acc_q >> AVG_LOG2);
                        end
                    end
                    err_d = err_q & ~ch_sel;
                    acc_d = '0;
                    cnt_d = '0;
                    if (ch_q == 2'd2) begin
                        state_d = DONE;
                        ch_d    = '0;
                    end else begin
                        state_d = REQ;
                        ch_d    = ch_q + 2'd1;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            DONE: begin
                ch_d  = '0;
                cnt_d = '0;
                acc_d = '0;
                tmo_d = '0;
                state_d = enable ? REQ : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin : output_logic
        adc_req_d      = (state_d == REQ);
        adc_ch_d       = ch_d;
        sample_valid_d = (state_d == DONE);
        busy_d         = (state_d != IDLE);
    end

    assign adc_req      = adc_req_q;
    assign adc_ch       = adc_ch_q;
    assign sen_1        = sen_q[0];
    assign sen_2        = sen_q[1];
    assign sen_3        = sen_q[2];
    assign sample_valid = sample_valid_q;
    assign err          = err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sensor_sampler.sv
// Directed-plus-random bench for sensor_sampler: an ADC responder feeds samples and a
// frame-level model predicts averages, error flags and frame length.
module tb_sensor_sampler;

    localparam int AVG_LOG2 = 2;
    localparam int TIMEOUT  = 8;
    localparam int NS       = 1 << AVG_LOG2;
    localparam int NEVER    = 1000;

    logic        clk_16ms = 1'b0;
    logic        rst      = 1'b1;
    logic        enable   = 1'b0;
    logic        adc_req;
    logic [1:0]  adc_ch;
    logic        adc_ack  = 1'b0;
    logic [15:0] adc_data = 16'h0;
    logic [15:0] sen_1, sen_2, sen_3;
    logic        sample_valid;
    logic [2:0]  err;
    logic        busy;

    sensor_sampler #(.AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)) dut (
        .clk_16ms     (clk_16ms),
        .rst          (rst),
        .enable       (enable),
        .adc_req      (adc_req),
        .adc_ch       (adc_ch),
        .adc_ack      (adc_ack),
        .adc_data     (adc_data),
        .sen_1        (sen_1),
        .sen_2        (sen_2),
        .sen_3        (sen_3),
        .sample_valid (sample_valid),
        .err          (err),
        .busy         (busy)
    );

    always #5 clk_16ms = ~clk_16ms;

    int tests = 0;
    int fails = 0;

    // Frame-level reference state
    logic [15:0] exp_sen [3];
    logic [2:0]  exp_err;

    // ADC responder configuration and per-frame observations
    int     dly [3];
    int     hold;
    int     age;
    bit     prev_req;
    int     ack_left;
    longint sum [3];
    int     nacc [3];
    int     run_len [3];
    int     fixq [3][$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: look at the request, drive ack/data for the coming edge, advance.
    task automatic drive_cycle();
        int c;
        c = int'(adc_ch);
        if (c > 2) c = 2;
        if (adc_req) begin
            if (!prev_req) age = 0;
            if (age == dly[c]) ack_left = hold;
            run_len[c] = age + 1;
            age++;
        end
        prev_req = adc_req;
        if (ack_left > 0) begin
            adc_ack = 1'b1;
            if (adc_req && fixq[c].size() > 0) adc_data = 16'(fixq[c].pop_front());
            else                               adc_data = 16'($urandom);
            if (adc_req) begin
                sum[c]  += longint'(adc_data);
                nacc[c] += 1;
            end
            ack_left--;
        end else begin
            adc_ack  = 1'b0;
            adc_data = 16'($urandom);
        end
        @(negedge clk_16ms);
    endtask

    task automatic check_sens(input string name);
        check({name, " sen_1"}, 32'(sen_1), 32'(exp_sen[0]));
        check({name, " sen_2"}, 32'(sen_2), 32'(exp_sen[1]));
        check({name, " sen_3"}, 32'(sen_3), 32'(exp_sen[2]));
        check({name, " err"},   32'(err),   32'(exp_err));
    endtask

    // Runs one frame starting in an IDLE or DONE cycle; d >= TIMEOUT means the channel never acks.
    task automatic run_frame(input string name, input int d0, input int d1, input int d2,
                             input int h, input int drop_at, input bit keep_en);
        int n;
        int exp_len;
        bit done;
        bit ab [3];
        dly[0] = d0; dly[1] = d1; dly[2] = d2;
        hold = h; age = 0; ack_left = 0; prev_req = 1'b0;
        exp_len = 2;
        for (int c = 0; c < 3; c++) begin
            sum[c] = 0; nacc[c] = 0; run_len[c] = 0;
            ab[c] = (dly[c] >= TIMEOUT);
            if (ab[c]) exp_len += TIMEOUT + ((c < 2) ? 1 : 0);
            else       exp_len += NS * (dly[c] + 2);
        end
        n = 1;
        done = 1'b0;
        while (!done && n <= exp_len + 50) begin
            if (n == 2) check({name, " start"}, 32'({busy, adc_req, adc_ch}), 32'h0000_000C);
            if (n > 1 && sample_valid) begin
                done     = 1'b1;
                enable   = keep_en;
                adc_ack  = 1'b0;
                ack_left = 0;
                prev_req = 1'b0;
            end else begin
                enable = keep_en || (n < drop_at);
                drive_cycle();
                n++;
            end
        end
        check({name, " done"}, 32'(done), 32'd1);
        check({name, " frame_len"}, 32'(n), 32'(exp_len));
        for (int c = 0; c < 3; c++) begin
            if (ab[c]) begin
                exp_err[c] = 1'b1;
                check({name, " timeout_req_len"}, 32'(run_len[c]), 32'(TIMEOUT));
            end else begin
                exp_err[c] = 1'b0;
                exp_sen[c] = 16'(sum[c] / NS);
                check({name, " samples"}, 32'(nacc[c]), 32'(NS));
            end
        end
        check_sens(name);
        $display("[TB] frame %s: len=%0d sen=%0h/%0h/%0h err=%b", name, n, sen_1, sen_2, sen_3, err);
        if (!keep_en) begin
            @(negedge clk_16ms);
            check({name, " idle_after"}, 32'({sample_valid, busy, adc_req}), 32'd0);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int found;
        int seen;
        int d [3];
        bit ke;

        for (int c = 0; c < 3; c++) exp_sen[c] = '0;
        exp_err = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk_16ms);
        check("reset req/ch/busy/valid", 32'({adc_req, adc_ch, busy, sample_valid}), 32'd0);
        check_sens("reset");
        rst = 1'b0;

        // Known-data frame
        fixq[0] = '{100, 200, 300, 401};
        fixq[1] = '{65535, 65535, 65535, 65535};
        fixq[2] = '{7, 7, 7, 7};
        run_frame("known", 0, 0, 0, 1, 2, 1'b0);
        check("known sen_1 const", 32'(sen_1), 32'd250);
        check("known sen_2 const", 32'(sen_2), 32'h0000_FFFF);
        check("known sen_3 const", 32'(sen_3), 32'd7);

        // Channel 1 timeout keeps a previously stored value
        fixq[1] = '{32'h1234, 32'h1234, 32'h1234, 32'h1234};
        run_frame("preset", 0, 0, 0, 1, 2, 1'b0);
        run_frame("ch1_timeout", 0, NEVER, 0, 1, 2, 1'b0);
        check("ch1_timeout err const", 32'(err), 32'b010);
        check("ch1_timeout sen_2 const", 32'(sen_2), 32'h1234);
        run_frame("recover", 0, 0, 0, 1, 2, 1'b0);
        check("recover err const", 32'(err), 32'b000);

        // Ack on the last permitted cycle versus one cycle too late
        run_frame("boundary", TIMEOUT - 1, TIMEOUT, 0, 1, 2, 1'b0);
        run_frame("ch2_timeout", 1, 0, NEVER, 1, 2, 1'b0);

        // Random frames, some back to back
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 3; c++) d[c] = int'($urandom_range(0, TIMEOUT));
            ke = (i == 7) ? 1'b0 : 1'($urandom_range(0, 1));
            run_frame($sformatf("rand%0d", i), d[0], d[1], d[2], int'($urandom_range(1, 2)), 2, ke);
        end

        // Enable dropped during channel 1: frame still completes, then restart at channel 0
        run_frame("drop_en", 0, 0, 0, 1, 14, 1'b0);
        run_frame("restart", 0, 0, 0, 1, 2, 1'b0);

        // Delayed ack held for two cycles
        run_frame("delay3_hold2", 3, 3, 3, 2, 2, 1'b0);

        // Acks while IDLE are ignored
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            adc_ack  = 1'b1;
            adc_data = 16'($urandom);
            @(negedge clk_16ms);
        end
        adc_ack = 1'b0;
        check("idle_ack busy/req", 32'({busy, adc_req, sample_valid}), 32'd0);
        check_sens("idle_ack");

        // Reset during channel 2 accumulation
        dly[0] = 0; dly[1] = 0; dly[2] = 0;
        hold = 1; age = 0; ack_left = 0; prev_req = 1'b0;
        for (int c = 0; c < 3; c++) begin sum[c] = 0; nacc[c] = 0; end
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            if (adc_req && adc_ch == 2'd2 && nacc[2] == 2) begin
                found = 1;
            end else begin
                enable = (k == 0);
                drive_cycle();
            end
        end
        check("mid_rst reached ch2", 32'(found), 32'd1);
        rst = 1'b1; adc_ack = 1'b0; enable = 1'b0; ack_left = 0;
        @(negedge clk_16ms);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) exp_sen[c] = '0;
        exp_err = '0;
        check("mid_rst req/ch/busy/valid", 32'({adc_req, adc_ch, busy, sample_valid}), 32'd0);
        check_sens("mid_rst");
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            adc_ack  = (k < 3);
            adc_data = 16'($urandom);
            @(negedge clk_16ms);
            if (sample_valid || busy || adc_req) seen++;
        end
        adc_ack = 1'b0;
        check("late_ack ignored", 32'(seen), 32'd0);
        check_sens("late_ack");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
